// File: rtl/fetch_queue_ctrl_pkg.sv
// ============================================================================
// fetch_queue_ctrl_pkg : shared state encoding, sizing and count helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_queue_ctrl_pkg;

  localparam int MAXW          = 4;
  localparam int DEFAULT_DEPTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_t;

  // Requests of 5-7 words saturate to the per-cycle maximum.
  function automatic logic [2:0] clamp_cnt(input logic [2:0] cnt);
    return (cnt > 3'(MAXW)) ? 3'(MAXW) : cnt;
  endfunction

  function automatic logic [MAXW-1:0] therm_mask(input logic [2:0] n);
    logic [MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (3'(i) < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/queue_grant_calc.sv
// ============================================================================
// queue_grant_calc : grant = min(clamp(request), limit), purely combinational
// Rev 1.0
// ============================================================================
`default_nettype none

module queue_grant_calc
  import fetch_queue_ctrl_pkg::*;
#(
  parameter int LIM_W = 7
) (
  input  logic [2:0]       i_req,
  input  logic [LIM_W-1:0] i_limit,
  output logic [2:0]       o_grant
);

  logic [2:0] w_req_c;

  assign w_req_c = clamp_cnt(i_req);
  // When the limit wins it is below the clamped request, so it fits in 3 bits.
  assign o_grant = (LIM_W'(w_req_c) > i_limit) ? i_limit[2:0] : w_req_c;

endmodule

`default_nettype wire

// File: rtl/fetch_queue_ctrl.sv
// ============================================================================
// fetch_queue_ctrl : grant scheduler, shadow occupancy and flush sequencer
//                    for the four-port instruction FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue_ctrl
  import fetch_queue_ctrl_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             flush,
  input  logic [2:0]       fetch_cnt,
  input  logic [2:0]       decode_slots,
  output logic [2:0]       fetch_accept,
  output logic [2:0]       fifo_wen,
  output logic [2:0]       fifo_ren,
  output logic             fifo_rst_n,
  output logic [MAXW-1:0]  rd_valid_mask,
  output logic [OCC_W-1:0] occupancy,
  output logic             q_full,
  output logic             q_empty,
  output logic [1:0]       ctrl_state
);

  ctrl_state_t      r_state;
  logic [OCC_W-1:0] r_occ;
  logic [MAXW-1:0]  r_mask;

  logic             w_active;
  logic [2:0]       w_wreq;
  logic [2:0]       w_rreq;
  logic [OCC_W-1:0] w_free;
  logic [2:0]       w_wg;
  logic [2:0]       w_rg;
  logic [OCC_W:0]   w_occ_sum;

  assign w_active = (r_state == ST_RUN) && !flush;
  assign w_wreq   = w_active ? fetch_cnt    : 3'd0;
  assign w_rreq   = w_active ? decode_slots : 3'd0;
  assign w_free   = OCC_W'(DEPTH) - r_occ;

  queue_grant_calc #(.LIM_W(OCC_W)) u_wr_grant (
    .i_req   (w_wreq),
    .i_limit (w_free),
    .o_grant (w_wg)
  );

  // Limit of zero on an empty queue keeps reads off a FIFO being written.
  queue_grant_calc #(.LIM_W(OCC_W)) u_rd_grant (
    .i_req   (w_rreq),
    .i_limit (r_occ),
    .o_grant (w_rg)
  );

  assign w_occ_sum = (OCC_W+1)'(r_occ) + (OCC_W+1)'(w_wg) - (OCC_W+1)'(w_rg);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_occ   <= '0;
      r_mask  <= '0;
    end else begin
      if (flush) begin
        r_occ  <= '0;
        r_mask <= '0;
      end else begin
        r_occ  <= w_occ_sum[OCC_W-1:0];
        r_mask <= therm_mask(w_rg);
      end
      case (r_state)
        ST_IDLE:  if (flush) r_state <= ST_FLUSH;
                  else if (enable) r_state <= ST_RUN;
        ST_RUN:   if (flush) r_state <= ST_FLUSH;
                  else if (!enable) r_state <= ST_IDLE;
        ST_FLUSH: if (flush) r_state <= ST_FLUSH;
                  else if (enable) r_state <= ST_RUN;
                  else r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (w_occ_sum[OCC_W] == 1'b0);
  end

  assign fetch_accept  = w_wg;
  assign fifo_wen      = w_wg;
  assign fifo_ren      = w_rg;
  assign fifo_rst_n    = ~(reset | (r_state == ST_FLUSH));
  assign rd_valid_mask = r_mask;
  assign occupancy     = r_occ;
  assign q_full        = (r_occ == OCC_W'(DEPTH));
  assign q_empty       = (r_occ == '0);
  assign ctrl_state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue_ctrl.sv
// ============================================================================
// tb_fetch_queue_ctrl : directed vector table plus a held-flush sequence
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       flush;
  logic [2:0] fetch_cnt;
  logic [2:0] decode_slots;
  logic [2:0] fetch_accept;
  logic [2:0] fifo_wen;
  logic [2:0] fifo_ren;
  logic       fifo_rst_n;
  logic [3:0] rd_valid_mask;
  logic [6:0] occupancy;
  logic       q_full;
  logic       q_empty;
  logic [1:0] ctrl_state;

  int total = 0;
  int bad   = 0;

  fetch_queue_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .flush         (flush),
    .fetch_cnt     (fetch_cnt),
    .decode_slots  (decode_slots),
    .fetch_accept  (fetch_accept),
    .fifo_wen      (fifo_wen),
    .fifo_ren      (fifo_ren),
    .fifo_rst_n    (fifo_rst_n),
    .rd_valid_mask (rd_valid_mask),
    .occupancy     (occupancy),
    .q_full        (q_full),
    .q_empty       (q_empty),
    .ctrl_state    (ctrl_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       fl;
    logic [2:0] fc;
    logic [2:0] ds;
    logic [2:0] e_wen;
    logic [2:0] e_ren;
    logic       e_rstn;
    logic [3:0] e_mask;
    logic [6:0] e_occ;
    logic [1:0] e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic fl,
                     input logic [2:0] fc, input logic [2:0] ds,
                     input logic [2:0] wen, input logic [2:0] ren, input logic rstn,
                     input logic [3:0] mask, input logic [6:0] occ, input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.en = en; v.fl = fl; v.fc = fc; v.ds = ds;
    v.e_wen = wen; v.e_ren = ren; v.e_rstn = rstn;
    v.e_mask = mask; v.e_occ = occ; v.e_st = st;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic fl,
                       input logic [2:0] fc, input logic [2:0] ds);
    reset = rst; enable = en; flush = fl; fetch_cnt = fc; decode_slots = ds;
  endtask

  initial begin
    // Fill to full, top off at 62, clamp, flush after a read, empty-queue rule,
    // enable drop, held flush from IDLE, then reset mid-run at occupancy 33.
    add(1,0,0, 0,0, 0,0,0, 4'b0000, 0, 0);
    add(0,1,0, 4,0, 0,0,1, 4'b0000, 0, 0);
    for (int i = 0; i < 16; i++) add(0,1,0, 4,0, 4,0,1, 4'b0000, 7'(4*i), 1);
    add(0,1,0, 4,0, 0,0,1, 4'b0000, 64, 1);
    add(0,1,0, 0,2, 0,2,1, 4'b0000, 64, 1);
    add(0,1,0, 4,0, 2,0,1, 4'b0011, 62, 1);
    add(0,1,0, 0,7, 0,4,1, 4'b0000, 64, 1);
    add(0,1,0, 7,6, 4,4,1, 4'b1111, 60, 1);
    add(0,1,1, 4,4, 0,0,1, 4'b1111, 60, 1);
    add(0,1,0, 4,4, 0,0,0, 4'b0000, 0, 2);
    add(0,1,0, 3,4, 3,0,1, 4'b0000, 0, 1);
    add(0,1,0, 0,4, 0,3,1, 4'b0000, 3, 1);
    add(0,1,0, 0,0, 0,0,1, 4'b0111, 0, 1);
    add(0,1,0, 4,0, 4,0,1, 4'b0000, 0, 1);
    add(0,0,0, 4,4, 4,4,1, 4'b0000, 4, 1);
    add(0,0,0, 4,4, 0,0,1, 4'b1111, 4, 0);
    add(0,0,1, 0,0, 0,0,1, 4'b0000, 4, 0);
    add(0,0,1, 0,0, 0,0,0, 4'b0000, 0, 2);
    add(0,0,0, 0,0, 0,0,0, 4'b0000, 0, 2);
    add(0,0,0, 0,0, 0,0,1, 4'b0000, 0, 0);
    add(0,1,0, 4,0, 0,0,1, 4'b0000, 0, 0);
    for (int i = 0; i < 8; i++) add(0,1,0, 4,0, 4,0,1, 4'b0000, 7'(4*i), 1);
    add(0,1,0, 1,0, 1,0,1, 4'b0000, 32, 1);
    add(1,1,0, 0,0, 0,0,0, 4'b0000, 33, 1);
    add(1,1,0, 4,4, 0,0,0, 4'b0000, 0, 0);
    add(0,1,0, 0,0, 0,0,1, 4'b0000, 0, 0);

    drive(1,0,0,0,0);
    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      #1;
      drive(vecs[i].rst, vecs[i].en, vecs[i].fl, vecs[i].fc, vecs[i].ds);
      @(negedge clk);
      check("fifo_wen",      i, int'(fifo_wen),      int'(vecs[i].e_wen));
      check("fetch_accept",  i, int'(fetch_accept),  int'(vecs[i].e_wen));
      check("fifo_ren",      i, int'(fifo_ren),      int'(vecs[i].e_ren));
      check("fifo_rst_n",    i, int'(fifo_rst_n),    int'(vecs[i].e_rstn));
      check("rd_valid_mask", i, int'(rd_valid_mask), int'(vecs[i].e_mask));
      check("occupancy",     i, int'(occupancy),     int'(vecs[i].e_occ));
      check("ctrl_state",    i, int'(ctrl_state),    int'(vecs[i].e_st));
      check("q_full",        i, int'(q_full),        (vecs[i].e_occ == 7'd64) ? 1 : 0);
      check("q_empty",       i, int'(q_empty),       (vecs[i].e_occ == 7'd0)  ? 1 : 0);
      @(posedge clk);
    end

    // Queue is in RUN and empty here; hold flush for three cycles.
    #1; drive(0,1,1,4,4);
    @(negedge clk);
    check("hold_flush_entry_wen", 100, int'(fifo_wen), 0);
    check("hold_flush_entry_st",  100, int'(ctrl_state), 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      if (k == 2) begin #1; drive(0,1,0,4,4); end
      @(negedge clk);
      check("hold_flush_st",   101 + k, int'(ctrl_state), 2);
      check("hold_flush_rstn", 101 + k, int'(fifo_rst_n), 0);
      check("hold_flush_wen",  101 + k, int'(fifo_wen), 0);
    end
    @(posedge clk);
    @(negedge clk);
    check("post_flush_st",   110, int'(ctrl_state), 1);
    check("post_flush_rstn", 110, int'(fifo_rst_n), 1);
    check("post_flush_wen",  110, int'(fifo_wen), 4);
    check("post_flush_ren",  110, int'(fifo_ren), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
